// File: rtl/dcmi_csr.sv
// DCMI control/status register file: capture config, interrupt block, registered reads.
// Define DCMI_CSR_SHADOW_EN to drive the capture config outputs from vsync-loaded shadow copies.
module dcmi_csr #(
   parameter int ADDR_W = 4,
   parameter int CROP_W = 14,
   parameter int DMA_AW = 18,
   parameter int DMA_LW = 18
) (
   input  logic                  hclk,
   input  logic                  rstn,
   input  logic                  ahb_bus_sel,
   input  logic                  ahb_bus_wr,
   input  logic                  ahb_bus_rd,
   input  logic [ADDR_W-1:0]     ahb_bus_addr,
   input  logic [3:0]            ahb_bus_bsel,
   input  logic [31:0]           ahb_bus_wdata,
   output logic [31:0]           ahb_bus_rdata,
   output logic                  ahb_bus_rvld,
   input  logic                  evt_line,
   input  logic                  evt_vsync,
   input  logic                  evt_frame,
   input  logic                  evt_ovr,
   input  logic                  evt_err,
   input  logic                  core_active,
   output logic [20:0]           cfg_cr,
   output logic [31:0]           cfg_escr,
   output logic [31:0]           cfg_esur,
   output logic [2*CROP_W-1:0]   cfg_crop_start,
   output logic [2*CROP_W-1:0]   cfg_crop_size,
   output logic [DMA_AW-1:0]     cfg_dma_saddr,
   output logic [DMA_LW-1:0]     cfg_dma_len,
   output logic                  irq
);

   logic [20:0]         cr_q, cr_d;
   logic [4:0]          ris_q, ris_d;
   logic [4:0]          ier_q, ier_d;
   logic [31:0]         escr_q, escr_d;
   logic [31:0]         esur_q, esur_d;
   logic [2*CROP_W-1:0] crop_start_q, crop_start_d;
   logic [2*CROP_W-1:0] crop_size_q, crop_size_d;
   logic [DMA_AW-1:0]   dma_saddr_q, dma_saddr_d;
   logic [DMA_LW-1:0]   dma_len_q, dma_len_d;
   logic                vsync_phase_q, vsync_phase_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                rvld_q, rvld_d;
   logic                irq_q, irq_d;

   logic [31:0] addr_w;
   logic [31:0] rd_val;
   logic [31:0] wr_m;
   logic        wr_en;
   logic        block_en;
   logic [4:0]  evt_g;
   logic [4:0]  icr_clr;

   function automatic logic [31:0] crop_word(input logic [2*CROP_W-1:0] f);
      logic [31:0] v;
      v = '0;
      v[CROP_W-1:0]  = f[CROP_W-1:0];
      v[16+:CROP_W]  = f[CROP_W+:CROP_W];
      return v;
   endfunction

   assign addr_w   = 32'(ahb_bus_addr);
   assign wr_en    = ahb_bus_sel & ahb_bus_wr;
   assign block_en = cr_q[14];
   // With the block disabled every event source is masked, including snapshot and vsync phase.
   assign evt_g    = {evt_frame, evt_ovr, evt_err, evt_vsync, evt_line} & {5{block_en}};

   always_comb begin
      rd_val = '0;
      case (addr_w)
         0:  rd_val[20:0] = cr_q;
         1:  rd_val[2:0]  = {ris_q[1], vsync_phase_q, core_active};
         2:  rd_val[4:0]  = ris_q;
         3:  rd_val[4:0]  = ier_q;
         4:  rd_val[4:0]  = ris_q & ier_q;
         6:  rd_val       = escr_q;
         7:  rd_val       = esur_q;
         8:  rd_val       = crop_word(crop_start_q);
         9:  rd_val       = crop_word(crop_size_q);
         10: rd_val[DMA_AW-1:0] = dma_saddr_q;
         11: rd_val[DMA_LW-1:0] = dma_len_q;
         default: rd_val = '0;
      endcase
   end

   // Byte-lane merge of the write data into the addressed register's current value.
   always_comb begin
      wr_m = rd_val;
      for (int b = 0; b < 4; b++) begin
         if (ahb_bus_bsel[b]) wr_m[8*b+:8] = ahb_bus_wdata[8*b+:8];
      end
   end

   always_comb begin
      cr_d          = cr_q;
      ier_d         = ier_q;
      escr_d        = escr_q;
      esur_d        = esur_q;
      crop_start_d  = crop_start_q;
      crop_size_d   = crop_size_q;
      dma_saddr_d   = dma_saddr_q;
      dma_len_d     = dma_len_q;
      icr_clr       = '0;

      if (cr_q[1] && evt_g[4]) cr_d[0] = 1'b0;

      if (wr_en) begin
         case (addr_w)
            0:  cr_d         = wr_m[20:0];
            3:  ier_d        = wr_m[4:0];
            5:  icr_clr      = ahb_bus_bsel[0] ? ahb_bus_wdata[4:0] : 5'd0;
            6:  escr_d       = wr_m;
            7:  esur_d       = wr_m;
            8:  crop_start_d = {wr_m[16+:CROP_W], wr_m[CROP_W-1:0]};
            9:  crop_size_d  = {wr_m[16+:CROP_W], wr_m[CROP_W-1:0]};
            10: dma_saddr_d  = wr_m[DMA_AW-1:0];
            11: dma_len_d    = wr_m[DMA_LW-1:0];
            default: ;
         endcase
      end

      ris_d         = block_en ? ((ris_q & ~icr_clr) | evt_g) : 5'd0;
      vsync_phase_d = vsync_phase_q ^ evt_g[1];
      irq_d         = |(ris_q & ier_q);
      rvld_d        = ahb_bus_sel & ahb_bus_rd;
      rdata_d       = rvld_d ? rd_val : rdata_q;
   end

   always_ff @(posedge hclk or negedge rstn) begin
      if (!rstn) begin
         cr_q          <= '0;
         ris_q         <= '0;
         ier_q         <= '0;
         escr_q        <= '0;
         esur_q        <= '0;
         crop_start_q  <= '0;
         crop_size_q   <= '0;
         dma_saddr_q   <= '0;
         dma_len_q     <= '0;
         vsync_phase_q <= 1'b0;
         rdata_q       <= '0;
         rvld_q        <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         cr_q          <= cr_d;
         ris_q         <= ris_d;
         ier_q         <= ier_d;
         escr_q        <= escr_d;
         esur_q        <= esur_d;
         crop_start_q  <= crop_start_d;
         crop_size_q   <= crop_size_d;
         dma_saddr_q   <= dma_saddr_d;
         dma_len_q     <= dma_len_d;
         vsync_phase_q <= vsync_phase_d;
         rdata_q       <= rdata_d;
         rvld_q        <= rvld_d;
         irq_q         <= irq_d;
      end
   end

   assign ahb_bus_rdata = rdata_q;
   assign ahb_bus_rvld  = rvld_q;
   assign irq           = irq_q;
   assign cfg_cr        = cr_q;

`ifdef DCMI_CSR_SHADOW_EN
   logic [31:0]         escr_sh_q, escr_sh_d;
   logic [31:0]         esur_sh_q, esur_sh_d;
   logic [2*CROP_W-1:0] crop_start_sh_q, crop_start_sh_d;
   logic [2*CROP_W-1:0] crop_size_sh_q, crop_size_sh_d;
   logic [DMA_AW-1:0]   dma_saddr_sh_q, dma_saddr_sh_d;
   logic [DMA_LW-1:0]   dma_len_sh_q, dma_len_sh_d;
   logic                sh_load;

   // Shadows track freely while idle and only move on a frame boundary while capturing.
   assign sh_load = evt_vsync | ~cr_q[0];

   always_comb begin
      escr_sh_d       = sh_load ? escr_q       : escr_sh_q;
      esur_sh_d       = sh_load ? esur_q       : esur_sh_q;
      crop_start_sh_d = sh_load ? crop_start_q : crop_start_sh_q;
      crop_size_sh_d  = sh_load ? crop_size_q  : crop_size_sh_q;
      dma_saddr_sh_d  = sh_load ? dma_saddr_q  : dma_saddr_sh_q;
      dma_len_sh_d    = sh_load ? dma_len_q    : dma_len_sh_q;
   end

   always_ff @(posedge hclk or negedge rstn) begin
      if (!rstn) begin
         escr_sh_q       <= '0;
         esur_sh_q       <= '0;
         crop_start_sh_q <= '0;
         crop_size_sh_q  <= '0;
         dma_saddr_sh_q  <= '0;
         dma_len_sh_q    <= '0;
      end else begin
         escr_sh_q       <= escr_sh_d;
         esur_sh_q       <= esur_sh_d;
         crop_start_sh_q <= crop_start_sh_d;
         crop_size_sh_q  <= crop_size_sh_d;
         dma_saddr_sh_q  <= dma_saddr_sh_d;
         dma_len_sh_q    <= dma_len_sh_d;
      end
   end

   assign cfg_escr       = escr_sh_q;
   assign cfg_esur       = esur_sh_q;
   assign cfg_crop_start = crop_start_sh_q;
   assign cfg_crop_size  = crop_size_sh_q;
   assign cfg_dma_saddr  = dma_saddr_sh_q;
   assign cfg_dma_len    = dma_len_sh_q;
`else
   assign cfg_escr       = escr_q;
   assign cfg_esur       = esur_q;
   assign cfg_crop_start = crop_start_q;
   assign cfg_crop_size  = crop_size_q;
   assign cfg_dma_saddr  = dma_saddr_q;
   assign cfg_dma_len    = dma_len_q;
`endif

endmodule

// File: tb/tb_dcmi_csr.sv
// Directed bench for dcmi_csr: register access, interrupt block, snapshot, block disable, shadows.
module tb_dcmi_csr;
   localparam int ADDR_W = 4;
   localparam int CROP_W = 14;
   localparam int DMA_AW = 18;
   localparam int DMA_LW = 18;

   logic                hclk = 1'b0;
   logic                rstn = 1'b1;
   logic                ahb_bus_sel = 1'b0;
   logic                ahb_bus_wr = 1'b0;
   logic                ahb_bus_rd = 1'b0;
   logic [ADDR_W-1:0]   ahb_bus_addr = '0;
   logic [3:0]          ahb_bus_bsel = '0;
   logic [31:0]         ahb_bus_wdata = '0;
   logic [31:0]         ahb_bus_rdata;
   logic                ahb_bus_rvld;
   logic                evt_line = 1'b0, evt_vsync = 1'b0, evt_frame = 1'b0;
   logic                evt_ovr = 1'b0, evt_err = 1'b0;
   logic                core_active = 1'b0;
   logic [20:0]         cfg_cr;
   logic [31:0]         cfg_escr, cfg_esur;
   logic [2*CROP_W-1:0] cfg_crop_start, cfg_crop_size;
   logic [DMA_AW-1:0]   cfg_dma_saddr;
   logic [DMA_LW-1:0]   cfg_dma_len;
   logic                irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 hclk = ~hclk;

   dcmi_csr #(.ADDR_W(ADDR_W), .CROP_W(CROP_W), .DMA_AW(DMA_AW), .DMA_LW(DMA_LW)) dut (
      .hclk(hclk), .rstn(rstn),
      .ahb_bus_sel(ahb_bus_sel), .ahb_bus_wr(ahb_bus_wr), .ahb_bus_rd(ahb_bus_rd),
      .ahb_bus_addr(ahb_bus_addr), .ahb_bus_bsel(ahb_bus_bsel), .ahb_bus_wdata(ahb_bus_wdata),
      .ahb_bus_rdata(ahb_bus_rdata), .ahb_bus_rvld(ahb_bus_rvld),
      .evt_line(evt_line), .evt_vsync(evt_vsync), .evt_frame(evt_frame),
      .evt_ovr(evt_ovr), .evt_err(evt_err), .core_active(core_active),
      .cfg_cr(cfg_cr), .cfg_escr(cfg_escr), .cfg_esur(cfg_esur),
      .cfg_crop_start(cfg_crop_start), .cfg_crop_size(cfg_crop_size),
      .cfg_dma_saddr(cfg_dma_saddr), .cfg_dma_len(cfg_dma_len), .irq(irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic bus_wr(input int a, input logic [31:0] d, input logic [3:0] be);
      ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1;
      ahb_bus_addr = ADDR_W'(a); ahb_bus_wdata = d; ahb_bus_bsel = be;
      step();
      ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0; ahb_bus_bsel = '0;
   endtask

   task automatic bus_rd(input int a, output logic [31:0] d, output logic v);
      ahb_bus_sel = 1'b1; ahb_bus_rd = 1'b1; ahb_bus_addr = ADDR_W'(a);
      step();
      ahb_bus_sel = 1'b0; ahb_bus_rd = 1'b0;
      d = ahb_bus_rdata;
      v = ahb_bus_rvld;
   endtask

   task automatic rd_check(input string tag, input int a, input logic [31:0] exp);
      logic [31:0] d;
      logic        v;
      bus_rd(a, d, v);
      check(tag, d, exp);
   endtask

   initial begin
      logic [31:0]         d;
      logic                v;
      logic [2*CROP_W-1:0] crop_new;
      logic [2*CROP_W-1:0] crop_all;
      crop_new = {14'h10, 14'h20};
      crop_all = {14'h3FFF, 14'h3FFF};

      // reset
      #2 rstn = 1'b0;
      step(); step();
      check("rst_rdata", ahb_bus_rdata, 32'h0);
      check("rst_rvld", {31'b0, ahb_bus_rvld}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      check("rst_cfg_cr", {11'b0, cfg_cr}, 32'h0);
      check("rst_cfg_escr", cfg_escr, 32'h0);
      rstn = 1'b1;
      step();

      for (int a = 0; a < 12; a++) begin
         bus_rd(a, d, v);
         check($sformatf("rst_read_%0d", a), d, 32'h0);
         check($sformatf("rst_rvld_%0d", a), {31'b0, v}, 32'h1);
      end
      step();
      check("rvld_drops", {31'b0, ahb_bus_rvld}, 32'h0);

      // byte-lane write
      bus_wr(6, 32'hA5C3_1E0F, 4'b0101);
      rd_check("escr_lanes", 6, 32'h00C3_000F);
      check("cfg_escr", cfg_escr, 32'h00C3_000F);

      // frame interrupt, irq latency, clear
      bus_wr(0, 32'h4000, 4'hF);
      bus_wr(3, 32'h1F, 4'hF);
      evt_frame = 1'b1; step(); evt_frame = 1'b0;
      check("irq_lat1", {31'b0, irq}, 32'h0);
      step();
      check("irq_lat2", {31'b0, irq}, 32'h1);
      rd_check("ris_frame", 2, 32'h10);
      rd_check("mis_frame", 4, 32'h10);
      bus_wr(5, 32'h10, 4'hF);
      rd_check("ris_cleared", 2, 32'h0);
      check("irq_cleared", {31'b0, irq}, 32'h0);

      // set beats clear
      evt_line = 1'b1;
      bus_wr(5, 32'h01, 4'hF);
      evt_line = 1'b0;
      rd_check("set_wins", 2, 32'h01);
      bus_wr(5, 32'h01, 4'hF);
      rd_check("line_cleared", 2, 32'h0);

      // status register
      core_active = 1'b1;
      evt_vsync = 1'b1; step(); evt_vsync = 1'b0;
      rd_check("sr_all", 1, 32'h7);
      rd_check("ris_vsync", 2, 32'h2);
      bus_wr(5, 32'h02, 4'hF);
      core_active = 1'b0;
      rd_check("sr_phase", 1, 32'h2);

      // snapshot
      bus_wr(0, 32'h4003, 4'hF);
      evt_frame = 1'b1; step(); evt_frame = 1'b0;
      rd_check("snapshot", 0, 32'h4002);
      evt_frame = 1'b1;
      bus_wr(0, 32'h4003, 4'hF);
      evt_frame = 1'b0;
      rd_check("snap_wr_wins", 0, 32'h4003);
      bus_wr(5, 32'h1F, 4'hF);

      // block disabled
      bus_wr(0, 32'h0000, 4'hF);
      evt_err = 1'b1; step(); evt_err = 1'b0;
      rd_check("blk_off_ris", 2, 32'h0);
      evt_vsync = 1'b1; step(); evt_vsync = 1'b0;
      rd_check("blk_off_sr", 1, 32'h2);

      // field truncation and unmapped space
      bus_wr(8, 32'hFFFF_FFFF, 4'hF);
      rd_check("cwstrt_trunc", 8, 32'h3FFF_3FFF);
      bus_wr(10, 32'hFFFF_FFFF, 4'hF);
      rd_check("saddr_trunc", 10, 32'h0003_FFFF);
      bus_wr(12, 32'hFFFF_FFFF, 4'hF);
      rd_check("unmapped", 12, 32'h0);
      rd_check("icr_reads0", 5, 32'h0);
      check("cfg_saddr", {14'b0, cfg_dma_saddr}, 32'h0003_FFFF);

      // shadowing under capture
      bus_wr(0, 32'h4001, 4'hF);
      bus_wr(8, 32'h0010_0020, 4'hF);
`ifdef DCMI_CSR_SHADOW_EN
      check("crop_held", {4'b0, cfg_crop_start}, {4'b0, crop_all});
`else
      check("crop_direct", {4'b0, cfg_crop_start}, {4'b0, crop_new});
`endif
      evt_vsync = 1'b1; step(); evt_vsync = 1'b0;
      check("crop_after_vsync", {4'b0, cfg_crop_start}, {4'b0, crop_new});
      rd_check("cwstrt_readback", 8, 32'h0010_0020);

      // reset in the middle of a write
      ahb_bus_sel = 1'b1; ahb_bus_wr = 1'b1; ahb_bus_addr = '0;
      ahb_bus_wdata = 32'hFFFF_FFFF; ahb_bus_bsel = 4'hF;
      #3 rstn = 1'b0;
      #2 ahb_bus_sel = 1'b0; ahb_bus_wr = 1'b0; ahb_bus_bsel = '0;
      step();
      check("midrst_irq", {31'b0, irq}, 32'h0);
      rstn = 1'b1;
      step();
      rd_check("midrst_cr", 0, 32'h0);
      rd_check("midrst_cwstrt", 8, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
